// File: rtl/qch_pkg.sv
// Shared types and widths for the Q-channel clock controller.
package qch_pkg;

  localparam int unsigned IDLE_CNT_W = 8;
  localparam int unsigned WAKE_CNT_W = 4;

  typedef enum logic [2:0] {
    RUN,
    REQUEST,
    STOPPED,
    WAKE,
    EXIT,
    DENIED
  } qch_state_e;

endpackage

// File: rtl/qch_idle_timer.sv
// Saturating count of consecutive idle cycles.
// Flags the tick that completes the idle window.
module qch_idle_timer
  import qch_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic tick_i,
  output logic expired_c_o
);

  localparam logic [IDLE_CNT_W-1:0] EXPIRE_AT = IDLE_CNT_W'(IDLE_CYCLES - 1);

  logic [IDLE_CNT_W-1:0] cnt_q;
  logic [IDLE_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Combinational so the request can issue on the edge that samples the last idle cycle.
  assign expired_c_o = tick_i && (cnt_q >= EXPIRE_AT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/qchannel_clk_ctrl.sv
// Q-channel controller: requests quiescence after an idle window and
// drives the external clock-gate enable through the handshake.
module qchannel_clk_ctrl
  import qch_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic enable_in,
  input  logic qactive_in,
  input  logic qacceptn_in,
  input  logic qdeny_in,
  output logic qreqn_out,
  output logic clk_en_out,
  output logic stopped_out,
  output logic proto_err_out
);

  localparam logic [WAKE_CNT_W-1:0] WAKE_LAST = WAKE_CNT_W'(WAKE_CYCLES - 1);

  qch_state_e            state_q, state_d;
  logic [WAKE_CNT_W-1:0] wake_q, wake_d;
  logic                  qreqn_q, qreqn_d;
  logic                  clk_en_q, clk_en_d;
  logic                  stopped_q, stopped_d;
  logic                  err_q, err_d;
  logic                  tick_c;
  logic                  expired_c;

  assign tick_c = (state_q == RUN) && !qactive_in && enable_in;

  qch_idle_timer #(
    .IDLE_CYCLES (IDLE_CYCLES)
  ) u_idle_timer (
    .clk_i       (clk_in),
    .rst_i       (rst_in),
    .clear_i     (!tick_c),
    .tick_i      (tick_c),
    .expired_c_o (expired_c)
  );

  always_comb begin
    state_d   = state_q;
    wake_d    = wake_q;
    err_d     = 1'b0;
    qreqn_d   = 1'b1;
    clk_en_d  = 1'b1;
    stopped_d = 1'b0;
    case (state_q)
      RUN: begin
        err_d = !qacceptn_in;
        if (expired_c) state_d = REQUEST;
      end
      REQUEST: begin
        // Deny takes priority over a simultaneous accept.
        if (qdeny_in) begin
          state_d = DENIED;
          err_d   = !qacceptn_in;
        end else if (!qacceptn_in) begin
          state_d = STOPPED;
        end
      end
      STOPPED: begin
        err_d = qdeny_in;
        if (qactive_in || !enable_in) begin
          state_d = WAKE;
          wake_d  = '0;
        end
      end
      WAKE: begin
        err_d = qdeny_in;
        if (wake_q == WAKE_LAST) state_d = EXIT;
        else                     wake_d  = wake_q + 1'b1;
      end
      EXIT: begin
        err_d = qdeny_in;
        if (qacceptn_in) state_d = RUN;
      end
      DENIED: begin
        if (!qdeny_in) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    // Outputs are registered from the next state so they track state_q exactly.
    qreqn_d   = (state_d == RUN) || (state_d == EXIT) || (state_d == DENIED);
    clk_en_d  = (state_d != STOPPED);
    stopped_d = (state_d == STOPPED);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= RUN;
      wake_q    <= '0;
      qreqn_q   <= 1'b1;
      clk_en_q  <= 1'b1;
      stopped_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wake_q    <= wake_d;
      qreqn_q   <= qreqn_d;
      clk_en_q  <= clk_en_d;
      stopped_q <= stopped_d;
      err_q     <= err_d;
    end
  end

  assign qreqn_out     = qreqn_q;
  assign clk_en_out    = clk_en_q;
  assign stopped_out   = stopped_q;
  assign proto_err_out = err_q;

endmodule

// File: tb/tb_qchannel_clk_ctrl.sv
// Scenario bench for qchannel_clk_ctrl with IDLE_CYCLES=4, WAKE_CYCLES=2.
module tb_qchannel_clk_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic act = 1'b1;
  logic accn = 1'b1;
  logic deny = 1'b0;
  logic qreqn, clk_en, stopped, err;

  int total = 0;
  int bad = 0;

  // {qreqn, clk_en, stopped, proto_err} expected after the edge
  logic [3:0] sb_q[$];

  always #5 clk = ~clk;

  qchannel_clk_ctrl #(
    .IDLE_CYCLES (4),
    .WAKE_CYCLES (2)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .enable_in     (en),
    .qactive_in    (act),
    .qacceptn_in   (accn),
    .qdeny_in      (deny),
    .qreqn_out     (qreqn),
    .clk_en_out    (clk_en),
    .stopped_out   (stopped),
    .proto_err_out (err)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0b exp=%0b", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic e, input logic a,
                      input logic acc, input logic d, input logic [3:0] exp);
    logic [3:0] want;
    rst  = r;
    en   = e;
    act  = a;
    accn = acc;
    deny = d;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    want = sb_q.pop_front();
    check({tag, ".qreqn"},   qreqn,   want[3]);
    check({tag, ".clk_en"},  clk_en,  want[2]);
    check({tag, ".stopped"}, stopped, want[1]);
    check({tag, ".err"},     err,     want[0]);
  endtask

  task automatic idle_to_request(input string tag);
    for (int i = 0; i < 3; i++) step({tag, ".idle"}, 0, 1, 0, 1, 0, 4'b1100);
    step({tag, ".req"}, 0, 1, 0, 1, 0, 4'b0100);
  endtask

  initial begin
    step("reset0", 1, 1, 1, 1, 0, 4'b1100);
    step("reset1", 1, 1, 1, 1, 0, 4'b1100);

    // idle window, accept, stop
    idle_to_request("enter");
    step("req_hold",  0, 1, 0, 1, 0, 4'b0100);
    step("accept",    0, 1, 0, 0, 0, 4'b0010);
    step("stop_hold", 0, 1, 0, 0, 0, 4'b0010);

    // wake on activity, two wake cycles, exit handshake
    step("wake1",     0, 1, 1, 0, 0, 4'b0100);
    step("wake2",     0, 1, 1, 0, 0, 4'b0100);
    step("exit",      0, 1, 1, 0, 0, 4'b1100);
    step("exit_hold", 0, 1, 1, 0, 0, 4'b1100);
    step("to_run",    0, 1, 1, 1, 0, 4'b1100);

    // deny path, then a full fresh idle window
    idle_to_request("deny_pre");
    step("deny",      0, 1, 0, 1, 1, 4'b1100);
    step("deny_hold", 0, 1, 0, 1, 1, 4'b1100);
    step("undeny",    0, 1, 0, 1, 0, 4'b1100);
    idle_to_request("rereq");

    // enable dropped mid-handshake: completes, then wakes at once
    step("en0_req",   0, 0, 0, 1, 0, 4'b0100);
    step("en0_acc",   0, 0, 0, 0, 0, 4'b0010);
    step("en0_wake1", 0, 0, 0, 0, 0, 4'b0100);
    step("en0_wake2", 0, 0, 0, 0, 0, 4'b0100);
    step("en0_exit",  0, 0, 0, 0, 0, 4'b1100);
    step("en0_run",   0, 0, 0, 1, 0, 4'b1100);
    for (int i = 0; i < 5; i++) step("en0_idle", 0, 0, 0, 1, 0, 4'b1100);

    // interrupted idle run restarts the window
    for (int i = 0; i < 3; i++) step("brk_idle_a", 0, 1, 0, 1, 0, 4'b1100);
    step("brk_active", 0, 1, 1, 1, 0, 4'b1100);
    for (int i = 0; i < 3; i++) step("brk_idle_b", 0, 1, 0, 1, 0, 4'b1100);
    step("brk_req", 0, 1, 0, 1, 0, 4'b0100);

    // accept and deny together: deny wins with an error pulse
    step("both",     0, 1, 1, 0, 1, 4'b1101);
    step("both_clr", 0, 1, 1, 1, 0, 4'b1100);

    // accept while running is an error and otherwise ignored
    step("run_acc",     0, 1, 1, 0, 0, 4'b1101);
    step("run_acc_clr", 0, 1, 1, 1, 0, 4'b1100);

    // deny while stopped is an error and otherwise ignored
    idle_to_request("stop_pre");
    step("stop_acc",    0, 1, 0, 0, 0, 4'b0010);
    step("stop_deny",   0, 1, 0, 0, 1, 4'b0011);
    step("stop_undeny", 0, 1, 0, 0, 0, 4'b0010);

    // reset while stopped
    step("rst_stop", 1, 1, 0, 1, 0, 4'b1100);
    step("post_rst", 0, 1, 1, 1, 0, 4'b1100);

    check("sb_empty", sb_q.size() == 0, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
